// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding, parity modes
// and the parity check helper.
package serial_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Wide enough for the largest legal bit period (4095 clocks).
  localparam int TIMER_W = 12;

  // Returns 1 when the received parity bit disagrees with the data under the
  // selected mode; never flags anything when parity is disabled.
  function automatic logic parity_bad(input logic data_xor, input logic par_bit,
                                      input int mode);
    logic sum;
    sum = data_xor ^ par_bit;
    if (mode == PARITY_EVEN) return sum;
    if (mode == PARITY_ODD)  return ~sum;
    return 1'b0;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period counter for the serial receiver. Produces a mid-bit strobe used
// to validate the start bit and a per-bit strobe one full period after each
// restart, which marks every later sample point.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic mid_o,
  output logic bit_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(CLKS_PER_BIT - 1);
  // The cycle of the restart counts as count 0, so the half-bit point is
  // reached when the register shows HALF-1.
  localparam logic [TIMER_W-1:0] MID  = (HALF > 0) ? TIMER_W'(HALF - 1) : '0;

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Count up, wrapping at the end of each bit period or on restart.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || cnt_q == LAST) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign mid_o = (cnt_q == MID);
  assign bit_o = (cnt_q == LAST);

endmodule

// File: rtl/serial_rx_param.sv
// Parameterised asynchronous serial receiver with optional parity, one or two
// stop bits, a single-word holding register with valid/ready handshake, and
// sticky overrun reporting.
module serial_rx_param
  import serial_pkg::*;
#(
  parameter int DATA_BITS    = 7,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [4:0] LAST_DATA = 5'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_bad_q, par_bad_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  logic restart, mid_stb, bit_stb, frame_done, frame_ferr;

  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .mid_o     (mid_stb),
    .bit_o     (bit_stb)
  );

  // Frame FSM: start validation, data shifting, parity and stop sampling.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_bad_d  = par_bad_q;
    ferr_acc_d = ferr_acc_q;
    restart    = 1'b0;
    frame_done = 1'b0;
    frame_ferr = ferr_acc_q | ~serial_in;
    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        if (!serial_in) begin
          state_d    = ST_START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_bad_d  = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      ST_START: begin
        if (mid_stb) begin
          restart = 1'b1;
          if (CLKS_PER_BIT == 1) begin
            // One clock per bit leaves no room for a mid-bit check, so this
            // cycle already carries data bit 0.
            shift_d   = {serial_in, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = 5'd1;
            state_d   = ST_DATA;
          end else if (serial_in) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bit_stb) begin
          shift_d = {serial_in, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_stb) begin
          par_bad_d = parity_bad(^shift_q, serial_in, PARITY_MODE);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_stb) begin
          ferr_acc_d = frame_ferr;
          if (stop_cnt_q == STOP_LAST) begin
            frame_done = 1'b1;
            state_d    = serial_in ? ST_IDLE : ST_BREAK;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (serial_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: load completed frames when free or being drained,
  // otherwise drop them and raise the sticky overrun flag.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = overrun_q;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        perr_d  = par_bad_q;
        ferr_d  = frame_ferr;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_bad_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_bad_q  <= par_bad_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
